// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_pkg: state encoding and sizing shared by the AES round controller |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package aes_pkg;

   localparam int AES_NUM_ROUNDS = 10;
   localparam int AES_KEY_ADDR_W = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      ROUND   = 3'd2,
      FINAL   = 3'd3,
      HOLD    = 3'd4,
      KEYGEN  = 3'd5,
      KEYWAIT = 3'd6
   } aes_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_round_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_round_controller: sequences one AES block through the round      |
// | datapath and owns rekeying. Optional macro AES_ROUND_CTRL_STATS_EN.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module aes_round_controller
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
   parameter int ADDR_W     = AES_KEY_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_start,
   input  logic              key_ready,
   output logic              key_gen_we,
   input  logic              fifo_empty,
   output logic              read_fifo,
   output logic              load_state,
   output logic              round_en,
   output logic              final_round,
   output logic [ADDR_W-1:0] round_key_addr,
   output logic              data_valid,
   input  logic              out_ready,
   output logic              data_done,
   output logic              busy
`ifdef AES_ROUND_CTRL_STATS_EN
   ,
   output logic [31:0]       blk_count,
   output logic [15:0]       stall_count
`endif
);

   localparam logic [ADDR_W-1:0] FIRST_MID = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_MID  = ADDR_W'(NUM_ROUNDS - 1);
   localparam logic [ADDR_W-1:0] LAST_KEY  = ADDR_W'(NUM_ROUNDS);

   aes_ctrl_state_t   state_q, state_d;
   logic [ADDR_W-1:0] counter_q, counter_d;
   logic              key_valid_q, key_valid_d;
   logic              key_pending_q, key_pending_d;
   logic              wait_armed_q, wait_armed_d;
   logic              key_gen_we_q, key_gen_we_d;
   logic              load_state_q, load_state_d;
   logic              round_en_q, round_en_d;
   logic              final_round_q, final_round_d;
   logic [ADDR_W-1:0] round_key_addr_q, round_key_addr_d;
   logic              data_valid_q, data_valid_d;
   logic              busy_q, busy_d;
   logic              start_block;
   logic              rekey_req;

   assign rekey_req   = key_start || key_pending_q;
   assign start_block = (state_q == IDLE) && !rekey_req && key_valid_q && !fifo_empty;

   always_comb begin
      state_d       = state_q;
      counter_d     = counter_q;
      key_valid_d   = key_valid_q;
      key_pending_d = key_pending_q || key_start;
      wait_armed_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rekey_req) begin
               state_d = KEYGEN;
            end else if (start_block) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            counter_d = FIRST_MID;
            state_d   = ROUND;
         end
         ROUND: begin
            counter_d = counter_q + 1'b1;
            if (counter_q == LAST_MID) begin
               state_d = FINAL;
            end
         end
         FINAL: state_d = HOLD;
         HOLD: begin
            if (out_ready) begin
               counter_d = '0;
               state_d   = IDLE;
            end
         end
         KEYGEN: begin
            key_valid_d   = 1'b0;
            key_pending_d = key_start;
            state_d       = KEYWAIT;
         end
         KEYWAIT: begin
            // The entry cycle is never armed, so a key_ready level left over
            // from the previous expansion cannot end the wait early.
            wait_armed_d = 1'b1;
            if (wait_armed_q && key_ready) begin
               key_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      key_gen_we_d  = (state_d == KEYGEN);
      load_state_d  = (state_d == FETCH);
      round_en_d    = (state_d == ROUND) || (state_d == FINAL);
      final_round_d = (state_d == FINAL);
      data_valid_d  = (state_d == HOLD);
      busy_d        = (state_d != IDLE);
      if (state_d == ROUND) begin
         round_key_addr_d = counter_d;
      end else if (state_d == FINAL) begin
         round_key_addr_d = LAST_KEY;
      end else begin
         round_key_addr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         counter_q        <= '0;
         key_valid_q      <= 1'b0;
         key_pending_q    <= 1'b0;
         wait_armed_q     <= 1'b0;
         key_gen_we_q     <= 1'b0;
         load_state_q     <= 1'b0;
         round_en_q       <= 1'b0;
         final_round_q    <= 1'b0;
         round_key_addr_q <= '0;
         data_valid_q     <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         counter_q        <= counter_d;
         key_valid_q      <= key_valid_d;
         key_pending_q    <= key_pending_d;
         wait_armed_q     <= wait_armed_d;
         key_gen_we_q     <= key_gen_we_d;
         load_state_q     <= load_state_d;
         round_en_q       <= round_en_d;
         final_round_q    <= final_round_d;
         round_key_addr_q <= round_key_addr_d;
         data_valid_q     <= data_valid_d;
         busy_q           <= busy_d;
      end
   end

   // Pop and handshake strobes react to this cycle's inputs; reset masks them.
   assign read_fifo      = !rst && start_block;
   assign data_done      = !rst && (state_q == HOLD) && out_ready;
   assign key_gen_we     = key_gen_we_q;
   assign load_state     = load_state_q;
   assign round_en       = round_en_q;
   assign final_round    = final_round_q;
   assign round_key_addr = round_key_addr_q;
   assign data_valid     = data_valid_q;
   assign busy           = busy_q;

`ifdef AES_ROUND_CTRL_STATS_EN
   logic [31:0] blk_count_q, blk_count_d;
   logic [15:0] stall_count_q, stall_count_d;

   always_comb begin
      blk_count_d   = blk_count_q;
      stall_count_d = stall_count_q;
      if (state_d == KEYGEN) begin
         blk_count_d   = '0;
         stall_count_d = '0;
      end else begin
         if (data_done) begin
            blk_count_d = blk_count_q + 32'd1;
         end
         if ((state_q == HOLD) && !out_ready && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_count_q   <= '0;
         stall_count_q <= '0;
      end else begin
         blk_count_q   <= blk_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign blk_count   = blk_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_aes_round_controller: scoreboard bench for aes_round_controller    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_aes_round_controller;

   localparam int NR = 10;
   localparam int AW = 4;

   localparam int K_READ  = 0;
   localparam int K_LOAD  = 1;
   localparam int K_ROUND = 2;
   localparam int K_FINAL = 3;
   localparam int K_DONE  = 4;
   localparam int K_KEYWE = 5;

   typedef struct {
      int cyc;
      int kind;
      int addr;
      int extra;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_start = 1'b0;
   logic          key_ready = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          out_ready = 1'b0;
   logic          key_gen_we, read_fifo, load_state, round_en, final_round;
   logic [AW-1:0] round_key_addr;
   logic          data_valid, data_done, busy;
`ifdef AES_ROUND_CTRL_STATS_EN
   logic [31:0]   blk_count;
   logic [15:0]   stall_count;
`endif

   aes_round_controller #(.NUM_ROUNDS(NR), .ADDR_W(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .key_start      (key_start),
      .key_ready      (key_ready),
      .key_gen_we     (key_gen_we),
      .fifo_empty     (fifo_empty),
      .read_fifo      (read_fifo),
      .load_state     (load_state),
      .round_en       (round_en),
      .final_round    (final_round),
      .round_key_addr (round_key_addr),
      .data_valid     (data_valid),
      .out_ready      (out_ready),
      .data_done      (data_done),
      .busy           (busy)
`ifdef AES_ROUND_CTRL_STATS_EN
      ,
      .blk_count      (blk_count),
      .stall_count    (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t expq[$];
   bit  key_valid_m = 1'b0;
   int  blk_m = 0;
   int  stall_m = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, req);
      end
   endtask

   task automatic push_ev(input int c, input int kind, input int addr, input int extra);
      ev_t e;
      e.cyc = c; e.kind = kind; e.addr = addr; e.extra = extra;
      expq.push_back(e);
   endtask

   // Monitor: every strobe the DUT raises must match the head of the queue.
   int  dv_run = 0;
   int  mon_kind;
   bit  mon_have;
   ev_t mon_e;
   always @(negedge clk) begin
      if (data_valid) dv_run++;
      mon_have = 1'b1;
      mon_kind = 0;
      if (read_fifo)                    mon_kind = K_READ;
      else if (load_state)              mon_kind = K_LOAD;
      else if (round_en && final_round) mon_kind = K_FINAL;
      else if (round_en)                mon_kind = K_ROUND;
      else if (data_done)               mon_kind = K_DONE;
      else if (key_gen_we)              mon_kind = K_KEYWE;
      else                              mon_have = 1'b0;
      checks++;
      if (mon_have) begin
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cycle %0d kind %0d addr %0d, none expected",
                     cyc, mon_kind, round_key_addr);
         end else begin
            mon_e = expq.pop_front();
            if (mon_e.cyc != cyc || mon_e.kind != mon_kind || mon_e.addr != int'(round_key_addr)) begin
               errors++;
               $display("FAIL event: got cycle %0d kind %0d addr %0d expected cycle %0d kind %0d addr %0d",
                        cyc, mon_kind, round_key_addr, mon_e.cyc, mon_e.kind, mon_e.addr);
            end else if (mon_kind == K_DONE && dv_run != mon_e.extra) begin
               errors++;
               $display("FAIL valid_len: cycle %0d data_valid cycles %0d expected %0d",
                        cyc, dv_run, mon_e.extra);
            end
         end
      end else if (round_key_addr != '0 || final_round) begin
         errors++;
         $display("FAIL idle_addr: cycle %0d addr %0d final %0b expected 0 0",
                  cyc, round_key_addr, final_round);
      end
      if (!data_valid) dv_run = 0;
   end

   function automatic int all_outputs();
      return int'({key_gen_we, read_fifo, load_state, round_en, final_round,
                   round_key_addr, data_valid, data_done, busy});
   endfunction

   // Key expansion wait starting at KEYGEN cycle g; KEYWE at g already queued.
   task automatic rekey_tail(input int g_in, input int stale_in, input int dly_in, input bit again);
      int g, n, stale, dly, r, a;
      g = g_in;
      n = again ? 2 : 1;
      for (int j = 0; j < n; j++) begin
         stale = (j == 0 && stale_in >= 0) ? stale_in : int'($urandom_range(0, 1));
         dly   = (j == 0 && dly_in >= 2) ? dly_in : int'($urandom_range(2, 6));
         r = (stale != 0) ? g : g + dly;
         a = (r > g + 2) ? r : g + 2;
         wait_until(g);
         key_ready = (stale != 0);
         fifo_empty = 1'b0;
         key_valid_m = 1'b0;
         blk_m = 0;
         stall_m = 0;
         wait_until(g + 1);
         check("keywait_busy", int'(busy), 1);
         if (again && j == 0) key_start = 1'b1;
         wait_until(g + 2);
         key_start = 1'b0;
         for (int t = g + 2; t <= a; t++) begin
            wait_until(t);
            if (t == r) key_ready = 1'b1;
         end
         wait_until(a + 1);
         fifo_empty = 1'b1;
         key_ready = 1'($urandom_range(0, 1));
         if (j + 1 < n) begin
            push_ev(a + 2, K_KEYWE, 0, 0);
            g = a + 2;
         end
      end
      key_valid_m = 1'b1;
   endtask

   task automatic do_rekey(input bit fifo_busy, input int stale, input int dly, input bit again);
      int c;
      c = cyc;
      check("idle_busy", int'(busy), 0);
      key_start = 1'b1;
      fifo_empty = !fifo_busy;
      push_ev(c + 1, K_KEYWE, 0, 0);
      wait_until(c + 1);
      key_start = 1'b0;
      rekey_tail(c + 1, stale, dly, again);
   endtask

   // One block: s stall cycles, rekey request at round kmid, or reset at round krst.
   task automatic do_block(input int s, input int kmid, input int krst);
      int c, d, last;
      c = cyc;
      check("idle_busy", int'(busy), 0);
      if (!key_valid_m) begin
         fifo_empty = 1'b0;
         wait_until(c + 3);
         fifo_empty = 1'b1;
         return;
      end
      last = (krst > 0) ? krst : NR - 1;
      push_ev(c, K_READ, 0, 0);
      push_ev(c + 1, K_LOAD, 0, 0);
      for (int i = 1; i <= last; i++) push_ev(c + 1 + i, K_ROUND, i, 0);
      d = c + NR + 2 + s;
      if (krst == 0) begin
         push_ev(c + NR + 1, K_FINAL, NR, 0);
         push_ev(d, K_DONE, 0, s + 1);
      end
      fifo_empty = 1'b0;
      out_ready = 1'b0;
      wait_until(c + 1);
      fifo_empty = 1'b1;
      if (krst > 0) begin
         wait_until(c + 1 + krst);
         rst = 1'b1;
         wait_until(c + 2 + krst);
         rst = 1'b0;
         check("reset_outputs", all_outputs(), 0);
         key_valid_m = 1'b0;
         blk_m = 0;
         stall_m = 0;
         fifo_empty = 1'b0;
         wait_until(c + 5 + krst);
         fifo_empty = 1'b1;
         return;
      end
      if (kmid > 0) begin
         wait_until(c + 1 + kmid);
         key_start = 1'b1;
         wait_until(c + 2 + kmid);
         key_start = 1'b0;
      end
      wait_until(d);
      out_ready = 1'b1;
      blk_m++;
      stall_m += s;
      wait_until(d + 1);
      out_ready = 1'b0;
      if (kmid > 0) begin
         fifo_empty = 1'b0;
         push_ev(d + 2, K_KEYWE, 0, 0);
         rekey_tail(d + 2, -1, -1, 1'b0);
      end
   endtask

   initial begin
      int op;
      step();
      step();
      check("reset_outputs", all_outputs(), 0);
      rst = 1'b0;
      step();
      check("post_reset_outputs", all_outputs(), 0);

      do_rekey(1'b0, 0, 4, 1'b0);
      do_block(0, 0, 0);
      do_block(7, 0, 0);
      do_block(2, 4, 0);
      do_block(0, 0, 6);
      do_block(0, 0, 0);
      do_rekey(1'b1, 1, 0, 1'b1);
      do_block(1, 0, 0);

      for (int n = 0; n < 30; n++) begin
         op = int'($urandom_range(0, 9));
         if (!key_valid_m || op <= 1) begin
            do_rekey(1'($urandom_range(0, 1)), -1, -1, 1'b0);
         end else if (op <= 5) begin
            do_block(int'($urandom_range(0, 4)), 0, 0);
         end else if (op == 6) begin
            do_block(int'($urandom_range(0, 3)), int'($urandom_range(1, NR - 1)), 0);
         end else if (op == 7) begin
            do_block(0, 0, int'($urandom_range(1, NR - 1)));
         end else if (op == 8) begin
            wait_until(cyc + int'($urandom_range(1, 3)));
         end else begin
            do_rekey(1'b1, -1, -1, 1'b1);
         end
      end

      wait_until(cyc + 20);
      check("queue_drained", expq.size(), 0);
      check("final_busy", int'(busy), 0);
`ifdef AES_ROUND_CTRL_STATS_EN
      check("blk_count", int'(blk_count), blk_m);
      check("stall_count", int'(stall_count), stall_m);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
